// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with HI/LO result registers.
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   rst     : synchronous active-high reset (priority over every other input)
//   A, B    : operands (multiplicand/dividend, multiplier/divisor)
//   MDctrl  : operation select (op_mult, op_multu, op_div, op_divu)
//   start   : begin an operation (accepted only while idle)
//   hi_we   : direct write of HI from wdata (idle only)
//   lo_we   : direct write of LO from wdata (idle only)
//   wdata   : data for the direct writes
//   busy    : operation in progress (32 cycles)
//   done    : one-cycle pulse in the first idle cycle after an operation
//   HI, LO  : product {HI,LO}, or remainder (HI) and quotient (LO)
//
// Both operations work on operand magnitudes in a shared 64-bit work
// register: the multiply shifts right with a conditional add into the upper
// half, and the restoring divide shifts the {remainder, quotient} pair left,
// producing one quotient bit per cycle. Signs are restored at completion.

module muldiv_unit #(
    parameter logic [1:0] op_mult  = 2'b00,
    parameter logic [1:0] op_multu = 2'b01,
    parameter logic [1:0] op_div   = 2'b10,
    parameter logic [1:0] op_divu  = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  MDctrl,
    input  logic        start,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [4:0]  cnt_r;
    logic [63:0] work_r;
    logic [31:0] opnd_r;
    logic [31:0] a_r;
    logic        is_div_r;
    logic        neg_q_r;
    logic        neg_a_r;
    logic        b_zero_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        accept_s;
    logic        run_s;
    logic        finish_s;
    logic        signed_op_s;
    logic        is_div_s;
    logic        sa_s;
    logic        sb_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] step_s;
    logic [63:0] prod_neg_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    assign busy = busy_r;
    assign done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> IDLE on the last iteration.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 5'd31) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        accept_s = 1'b0;
        run_s    = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start;
            end
            RUN: begin
                run_s    = 1'b1;
                finish_s = (cnt_r == 5'd31);
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Registered busy/done; done marks the completion edge for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == RUN);
            done_r <= finish_s;
        end
    end

    // Operand decode at acceptance: signedness and magnitudes.
    always_comb begin
        signed_op_s = (MDctrl == op_mult) || (MDctrl == op_div);
        is_div_s    = (MDctrl == op_div) || (MDctrl == op_divu);
        sa_s        = signed_op_s & A[31];
        sb_s        = signed_op_s & B[31];
        if (sa_s) begin
            mag_a_s = 32'd0 - A;
        end else begin
            mag_a_s = A;
        end
        if (sb_s) begin
            mag_b_s = 32'd0 - B;
        end else begin
            mag_b_s = B;
        end
    end

    // One iteration of the selected algorithm on the work register.
    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB is set, shift right.
        mul_sum_s  = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_next_s = {mul_sum_s, work_r[31:1]};
        // Divide: shift {rem, quo} left; keep the difference when it does not borrow.
        div_shift_s = {work_r[63:32], work_r[31]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (div_diff_s[32]) begin
            div_next_s = {div_shift_s[31:0], work_r[30:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[31:0], work_r[30:0], 1'b1};
        end
        if (is_div_r) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
    end

    // Sign correction and special cases applied to the final iteration.
    always_comb begin
        prod_neg_s = 64'd0 - step_s;
        res_hi_s   = step_s[63:32];
        res_lo_s   = step_s[31:0];
        if (is_div_r) begin
            if (b_zero_r) begin
                res_hi_s = a_r;
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                // Quotient takes A^B sign, remainder takes the dividend sign.
                // 80000000 / -1 yields magnitude 80000000 with positive sign,
                // which already reads back as 80000000.
                res_lo_s = neg_q_r ? (32'd0 - step_s[31:0])  : step_s[31:0];
                res_hi_s = neg_a_r ? (32'd0 - step_s[63:32]) : step_s[63:32];
            end
        end else begin
            if (neg_q_r) begin
                res_hi_s = prod_neg_s[63:32];
                res_lo_s = prod_neg_s[31:0];
            end else begin
                res_hi_s = step_s[63:32];
                res_lo_s = step_s[31:0];
            end
        end
    end

    // Datapath: latch operands on acceptance, iterate while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= 5'd0;
            work_r   <= 64'd0;
            opnd_r   <= 32'd0;
            a_r      <= 32'd0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_a_r  <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= 5'd0;
            a_r      <= A;
            is_div_r <= is_div_s;
            neg_q_r  <= sa_s ^ sb_s;
            neg_a_r  <= sa_s;
            b_zero_r <= (B == 32'd0);
            if (is_div_s) begin
                work_r <= {32'd0, mag_a_s};
                opnd_r <= mag_b_s;
            end else begin
                work_r <= {32'd0, mag_b_s};
                opnd_r <= mag_a_s;
            end
        end else if (run_s) begin
            cnt_r  <= cnt_r + 5'd1;
            work_r <= step_s;
        end
    end

    // HI/LO: result at completion, otherwise direct writes while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (finish_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (state_r == IDLE) begin
            if (hi_we) begin
                hi_r <= wdata;
            end
            if (lo_we) begin
                lo_r <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, expected {HI,LO} pushed into a
// scoreboard queue at issue time and compared by a monitor on each done pulse.

module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  MDctrl;
    logic        start;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_vec;
    int          n_err;
    logic [63:0] exp_q[$];

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .MDctrl (MDctrl),
        .start  (start),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got HI=%h LO=%h, required no done", HI, LO);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({HI, LO} !== e) begin
                    n_err++;
                    $display("FAIL result: got HI=%h LO=%h, required HI=%h LO=%h",
                             HI, LO, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Called at a negedge while busy; counts remaining busy samples.
    task automatic wait_complete(input int exp_busy);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, exp_busy);
        check("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_q.push_back({eh, el});
        @(negedge clk);
        A = a; B = b; MDctrl = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble operands after acceptance; the result must not change.
        A = 32'h5A5A_5A5A; B = 32'hA5A5_A5A5; MDctrl = ~op;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        issue(op, a, b, eh, el);
        wait_complete(32);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; A = 32'd0; B = 32'd0; MDctrl = 2'b00;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op(OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op(OP_DIVU,  32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFF);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // start and hi_we during RUN are ignored.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (9) @(negedge clk);
        A = 32'd3; B = 32'd3; MDctrl = OP_MULTU; start = 1'b1; hi_we = 1'b1; wdata = 32'd1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("run_hi_hold", HI, 32'h0000_0000);
        check("run_lo_hold", LO, 32'h8000_0000);
        wait_complete(22);
        repeat (3) @(negedge clk);
        check("no_restart", {31'd0, busy}, 32'd0);

        // Idle direct write of both registers.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("idle_hi_we", HI, 32'h1234_5678);
        check("idle_lo_we", LO, 32'h1234_5678);

        // Direct write together with start: write lands, result overwrites later.
        exp_q.push_back({32'h0000_0000, 32'h0000_0001});
        @(negedge clk);
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; MDctrl = OP_MULT; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("start_we_hi", HI, 32'hDEAD_BEEF);
        check("start_we_lo", LO, 32'hDEAD_BEEF);
        check("start_we_busy", {31'd0, busy}, 32'd1);
        wait_complete(32);

        // Reset at cycle 20 of a multu aborts it; start with rst is ignored.
        @(negedge clk);
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; MDctrl = OP_MULTU; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_idle", {31'd0, busy}, 32'd0);
        lo_we = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        lo_we = 1'b0;
        check("post_lo_we", LO, 32'h0000_ABCD);
        check("post_hi_keep", HI, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- op_mult, 2'b00, signed multiply
- op_multu, 2'b01, unsigned multiply
- op_div, 2'b10, signed divide
- op_divu, 2'b11, unsigned divide
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, clock; all state updates on the rising edge
- rst, input, 1, synchronous active-high reset
- A, input, 32, operand A (multiplicand or dividend)
- B, input, 32, operand B (multiplier or divisor)
- MDctrl, input, 2, operation select per REQ-001
- start, input, 1, request to begin an operation
- hi_we, input, 1, direct write of HI (mthi)
- lo_we, input, 1, direct write of LO (mtlo)
- wdata, input, 32, data for hi_we/lo_we
- busy, output, 1, operation in progress
- done, output, 1, one-cycle completion pulse
- HI, output, 32, high product word or remainder
- LO, output, 32, low product word or quotient

Function
REQ-004 Two states SHALL exist: IDLE (busy=0) and RUN (busy=1).
REQ-005 IDLE with start=1 at an edge SHALL latch A, B and MDctrl, clear a 5-bit iteration counter, and enter RUN.
REQ-006 RUN SHALL do one iteration per cycle:
- multiply: shift-add, 1 bit per cycle
- divide: restoring, 1 quotient bit per cycle
- operates on operand magnitudes; 32 iterations total
REQ-007 Completion edge (counter==31 in RUN) SHALL:
- apply sign correction
- write HI/LO
- return to IDLE
- set done=1 for exactly one cycle
REQ-008 Latency: busy high for exactly 32 cycles after the accepting edge; done high in the cycle after busy falls.
REQ-009 Multiply SHALL write the full 64-bit product, {HI,LO}.
- signed: two's-complement product of the signed operands
- unsigned: unsigned product
REQ-010 Divide SHALL write LO=quotient and HI=remainder.
- signed: quotient truncates toward zero; quotient sign = A[31]^B[31]; remainder sign = sign of A
REQ-011 Divide by zero (B==0, signed or unsigned) SHALL complete with normal latency and write LO=32'hFFFFFFFF, HI=A.
REQ-012 Signed 32'h80000000 / 32'hFFFFFFFF SHALL write LO=32'h80000000, HI=0.
REQ-013 start while RUN SHALL be ignored; the running operation continues unaffected.
REQ-014 hi_we/lo_we in IDLE SHALL write wdata into HI/LO at that edge.
- hi_we and lo_we both asserted: both HI and LO written
- in RUN: ignored
REQ-015 start together with hi_we/lo_we in IDLE SHALL:
- apply the direct write at that edge
- accept start
- overwrite HI/LO with the operation result at completion
REQ-016 HI and LO SHALL change only at the REQ-007 completion edge, on a REQ-014 write, or on reset; they hold between events.
REQ-017 Operand or MDctrl changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-018 rst=1 at an edge SHALL take priority over all other inputs and produce:
- state IDLE, counter 0
- busy=0, done=0
- HI=32'h0, LO=32'h0
REQ-019 Reset during RUN SHALL abort the operation: no done pulse, HI/LO cleared.
- start sampled together with rst is ignored

Verification
REQ-020 The bench SHALL cover these scenarios:
- multu A=FFFFFFFF, B=FFFFFFFF -> busy high 32 cycles, done pulses once, HI=FFFFFFFE, LO=00000001
- mult A=FFFFFFFD (-3), B=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB
- div A=FFFFFFF9 (-7), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; divu A=100, B=7 -> LO=14, HI=2
- div A=5, B=0 -> LO=FFFFFFFF, HI=5; div A=80000000, B=FFFFFFFF -> LO=80000000, HI=0
- divu 100/7 started; start (multu 3*3) and hi_we (wdata=1234) at cycle 10 -> both ignored; HI=2, LO=14 at completion
- rst at cycle 20 of a multu -> busy=0, HI=LO=0, no done; then lo_we with wdata=ABCD in IDLE -> LO=ABCD next cycle
